// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register + instruction fetch FSM (RST_WAIT/FETCH/EXEC).
// Ports: CLK, Resetl, BusImm, Branch, Uncondbranch, Zero, Commit,
//   imem_ready, imem_rdata -> imem_req, imem_addr, PC, Instr, InstrValid
//   (+ FetchErr and ERR state when IMEM_TIMEOUT_EN is defined).
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [7:0]  TIMEOUT_MAX = 8'd255
) (
  input  logic        CLK,
  input  logic        Resetl,
  input  logic [63:0] BusImm,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        Zero,
  input  logic        Commit,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic [63:0] PC,
  output logic [31:0] Instr,
`ifdef IMEM_TIMEOUT_EN
  output logic        InstrValid,
  output logic        FetchErr
`else
  output logic        InstrValid
`endif
);

`ifdef IMEM_TIMEOUT_EN
  typedef enum logic [1:0] {
    RST_WAIT,
    FETCH,
    EXEC,
    ERR
  } state_t;
`else
  typedef enum logic [1:0] {
    RST_WAIT,
    FETCH,
    EXEC
  } state_t;
`endif

  state_t      r_state;
  logic [63:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;

  logic        w_taken;
  logic [63:0] w_step;
  logic [63:0] w_next_pc;

  assign w_taken   = Uncondbranch | (Branch & Zero);
  assign w_step    = w_taken ? BusImm : 64'd4;
  assign w_next_pc = r_pc + w_step;

`ifdef IMEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;
  logic [7:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 8'd1;
  assign FetchErr  = r_err;
`else
  logic [7:0] w_unused_tmo;

  assign w_unused_tmo = TIMEOUT_MAX;
`endif

  always_ff @(posedge CLK or negedge Resetl) begin
    if (!Resetl) begin
      r_state <= RST_WAIT;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
`ifdef IMEM_TIMEOUT_EN
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        RST_WAIT: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
`ifdef IMEM_TIMEOUT_EN
          r_cnt   <= 8'd0;
`endif
        end
        FETCH: begin
          if (imem_ready) begin
            r_state <= EXEC;
            r_instr <= imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end
`ifdef IMEM_TIMEOUT_EN
          else begin
            r_cnt <= w_cnt_inc;
            // the wait that brings the count to the limit is the last one
            if (w_cnt_inc == TIMEOUT_MAX) begin
              r_state <= ERR;
              r_req   <= 1'b0;
              r_err   <= 1'b1;
            end
          end
`endif
        end
        EXEC: begin
          if (Commit) begin
            r_state <= FETCH;
            r_pc    <= w_next_pc;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
`ifdef IMEM_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
          end
        end
`ifdef IMEM_TIMEOUT_EN
        ERR: begin
          r_state <= ERR;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_err   <= 1'b1;
        end
`endif
        default: begin
          r_state <= RST_WAIT;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign PC         = r_pc;
  assign Instr      = r_instr;
  assign InstrValid = r_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table, random run against a model, and
// hand sequences for fetch stalls, resets and (optionally) timeout.
module tb_pc_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        CLK = 1'b0;
  logic        Resetl;
  logic [63:0] BusImm;
  logic        Branch;
  logic        Uncondbranch;
  logic        Zero;
  logic        Commit;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [63:0] PC;
  logic [31:0] Instr;
  logic        InstrValid;
`ifdef IMEM_TIMEOUT_EN
  logic        FetchErr;
`endif

  always #5 CLK = ~CLK;

  pc_fetch_unit #(
    .RESET_PC    (RST_PC),
    .TIMEOUT_MAX (8'd10)
  ) dut (
    .CLK          (CLK),
    .Resetl       (Resetl),
    .BusImm       (BusImm),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .Zero         (Zero),
    .Commit       (Commit),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .PC           (PC),
    .Instr        (Instr),
`ifdef IMEM_TIMEOUT_EN
    .InstrValid   (InstrValid),
    .FetchErr     (FetchErr)
`else
    .InstrValid   (InstrValid)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy;
    logic [31:0] rd;
    logic        cm;
    logic        br;
    logic        ub;
    logic        z;
    logic [63:0] imm;
    logic        ereq;
    logic        evld;
    logic [63:0] epc;
    logic [31:0] ein;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    BusImm       = 64'h0;
    Branch       = 1'b0;
    Uncondbranch = 1'b0;
    Zero         = 1'b0;
    Commit       = 1'b0;
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
  endtask

  task automatic do_reset;
    idle();
    Resetl = 1'b0;
    step();
    step();
    Resetl = 1'b1;
  endtask

  task automatic add(input logic rdy, input logic [31:0] rd,
                     input logic cm, input logic br, input logic ub,
                     input logic z, input logic [63:0] imm,
                     input logic ereq, input logic evld,
                     input logic [63:0] epc, input logic [31:0] ein);
    vec_t t;
    t.rdy = rdy; t.rd = rd; t.cm = cm; t.br = br; t.ub = ub;
    t.z = z; t.imm = imm; t.ereq = ereq; t.evld = evld;
    t.epc = epc; t.ein = ein;
    vecs.push_back(t);
  endtask

  task automatic chk_out(input string tag, input logic ereq,
                         input logic evld, input logic [63:0] epc,
                         input logic [31:0] ein);
    chk({tag, ".req"}, 64'(imem_req), 64'(ereq));
    chk({tag, ".vld"}, 64'(InstrValid), 64'(evld));
    chk({tag, ".pc"}, PC, epc);
    chk({tag, ".addr"}, imem_addr, epc);
    chk({tag, ".instr"}, 64'(Instr), 64'(ein));
  endtask

  // reference state: PC, held word, and whether a word is held
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  bit          m_held;

  initial begin
    int nreq;
    Resetl = 1'b0;
    idle();
    #1;
    chk_out("rst0", 1'b0, 1'b0, RST_PC, 32'h0);
    step();
    Resetl = 1'b1;
    chk("rel.req_before", 64'(imem_req), 64'd0);
    step();
    chk_out("rel.first", 1'b1, 1'b0, RST_PC, 32'h0);

    // ---- vector table (from FETCH at PC 0) ----
    add(1, 32'hA0, 1, 0, 0, 0, 0, 0, 1, 64'h0, 32'hA0);
    add(1, 32'hA1, 1, 0, 0, 0, 0, 1, 0, 64'h4, 32'hA0);
    add(1, 32'hA1, 1, 0, 0, 0, 0, 0, 1, 64'h4, 32'hA1);
    add(1, 32'hA2, 1, 0, 0, 0, 0, 1, 0, 64'h8, 32'hA1);
    add(1, 32'hA2, 1, 0, 0, 0, 0, 0, 1, 64'h8, 32'hA2);
    add(1, 32'hA3, 1, 0, 0, 0, 0, 1, 0, 64'hC, 32'hA2);
    add(1, 32'hA3, 1, 0, 0, 0, 0, 0, 1, 64'hC, 32'hA3);
    add(0, 0, 1, 0, 1, 0, 64'h34, 1, 0, 64'h40, 32'hA3);
    add(1, 32'hA4, 0, 0, 0, 0, 0, 0, 1, 64'h40, 32'hA4);
    add(0, 0, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0,
        1, 0, 64'h30, 32'hA4);
    add(1, 32'hA5, 0, 0, 0, 0, 0, 0, 1, 64'h30, 32'hA5);
    add(0, 0, 1, 0, 1, 0, 64'hD0, 1, 0, 64'h100, 32'hA5);
    add(1, 32'hA6, 0, 0, 0, 0, 0, 0, 1, 64'h100, 32'hA6);
    add(0, 0, 1, 1, 0, 0, 64'h20, 1, 0, 64'h104, 32'hA6);
    add(1, 32'hA7, 0, 0, 0, 0, 0, 0, 1, 64'h104, 32'hA7);
    add(0, 0, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC,
        1, 0, 64'h100, 32'hA7);
    add(1, 32'hA8, 0, 0, 0, 0, 0, 0, 1, 64'h100, 32'hA8);
    add(0, 0, 1, 1, 0, 1, 64'h20, 1, 0, 64'h120, 32'hA8);
    add(0, 0, 1, 1, 1, 1, 64'h80, 1, 0, 64'h120, 32'hA8);
    add(1, 32'hA9, 0, 0, 0, 0, 0, 0, 1, 64'h120, 32'hA9);
    add(1, 32'hAA, 0, 1, 1, 1, 64'h500, 0, 1, 64'h120, 32'hA9);
    add(0, 0, 1, 1, 0, 0, 64'h1000, 1, 0, 64'h124, 32'hA9);
    add(1, 32'hAA, 0, 0, 0, 0, 0, 0, 1, 64'h124, 32'hAA);
    add(0, 0, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FED8,
        1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hAA);
    add(1, 32'hAB, 0, 0, 0, 0, 0, 0, 1,
        64'hFFFF_FFFF_FFFF_FFFC, 32'hAB);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0, 64'h0, 32'hAB);

    foreach (vecs[i]) begin
      imem_ready   = vecs[i].rdy;
      imem_rdata   = vecs[i].rd;
      Commit       = vecs[i].cm;
      Branch       = vecs[i].br;
      Uncondbranch = vecs[i].ub;
      Zero         = vecs[i].z;
      BusImm       = vecs[i].imm;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].evld,
              vecs[i].epc, vecs[i].ein);
    end

    // ---- randomized run against the reference ----
    do_reset();
    step();
    m_pc    = RST_PC;
    m_instr = 32'h0;
    m_held  = 0;
    for (int n = 0; n < 400; n++) begin
      imem_ready   = ($urandom_range(0, 3) != 0);
      imem_rdata   = $urandom;
      Commit       = $urandom_range(0, 1) == 1;
      Branch       = $urandom_range(0, 1) == 1;
      Uncondbranch = $urandom_range(0, 3) == 0;
      Zero         = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0)
        BusImm = {$urandom, $urandom};
      else
        BusImm = 64'($urandom_range(0, 64)) * 64'd4;
      if (!m_held) begin
        if (imem_ready) begin
          m_instr = imem_rdata;
          m_held  = 1;
        end
      end else if (Commit) begin
        if (Uncondbranch || (Branch && Zero))
          m_pc = m_pc + BusImm;
        else
          m_pc = m_pc + 64'd4;
        m_held = 0;
      end
      step();
      chk_out($sformatf("rnd%0d", n), !m_held, m_held, m_pc, m_instr);
    end

    // ---- fetch stall: ready low 5 cycles then pulsed ----
    do_reset();
    nreq = 0;
    step();
    if (imem_req) nreq++;
    for (int k = 0; k < 5; k++) begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      if (imem_req) nreq++;
      chk($sformatf("stall%0d.pc", k), PC, RST_PC);
      chk($sformatf("stall%0d.instr", k), 64'(Instr), 64'h0);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h8B02_0020;
    step();
    idle();
    chk("stall.nreq", 64'(nreq), 64'd6);
    chk_out("stall.done", 1'b0, 1'b1, RST_PC, 32'h8B02_0020);

    // ---- Commit during FETCH ignored, then async reset mid-fetch ----
    do_reset();
    step();
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    idle();
    Commit = 1'b1;
    step();
    Commit       = 1'b1;
    Uncondbranch = 1'b1;
    BusImm       = 64'h40;
    step();
    chk_out("cmfetch", 1'b1, 1'b0, 64'h4, 32'h1234_5678);
    idle();
    #2;
    Resetl = 1'b0;
    #1;
    chk_out("arst.fetch", 1'b0, 1'b0, RST_PC, 32'h0);

    // ---- async reset mid-EXEC ----
    step();
    Resetl = 1'b1;
    step();
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    step();
    idle();
    chk_out("exec.pre", 1'b0, 1'b1, RST_PC, 32'hCAFE_F00D);
    #2;
    Resetl = 1'b0;
    #1;
    chk_out("arst.exec", 1'b0, 1'b0, RST_PC, 32'h0);

`ifdef IMEM_TIMEOUT_EN
    // ---- fetch timeout ----
    do_reset();
    step();
    chk("tmo.err0", 64'(FetchErr), 64'd0);
    for (int k = 0; k < 9; k++) step();
    chk("tmo.err9", 64'(FetchErr), 64'd0);
    chk("tmo.req9", 64'(imem_req), 64'd1);
    step();
    chk("tmo.err10", 64'(FetchErr), 64'd1);
    chk("tmo.req10", 64'(imem_req), 64'd0);
    imem_ready = 1'b1;
    Commit     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("tmo.hold%0d.err", k), 64'(FetchErr), 64'd1);
      chk($sformatf("tmo.hold%0d.req", k), 64'(imem_req), 64'd0);
      chk($sformatf("tmo.hold%0d.vld", k), 64'(InstrValid), 64'd0);
    end
    do_reset();
    chk("tmo.clr", 64'(FetchErr), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
